// File: rtl/clk_tick_counter_pkg.sv
// clk_tick_counter shared types and default sizes.
// Imported by the interface, prescaler and top.
package clk_tick_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_STEP  = 10;

endpackage

// File: rtl/clk_tick_counter_if.sv
// Control/status bundle of clk_tick_counter.
// master drives run/divide/load, slave returns tick outputs.
interface clk_tick_counter_if
  import clk_tick_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             en;
  logic [DIV_W-1:0] div;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             tick;
  logic             clk_div;
  logic [CNT_W-1:0] count;
  logic             wrap;

  modport master (
    output en, div, load, load_val,
    input  tick, clk_div, count, wrap
  );

  modport slave (
    input  en, div, load, load_val,
    output tick, clk_div, count, wrap
  );

endinterface

// File: rtl/clk_tick_counter_prescaler.sv
// Prescaler register with >= terminal compare.
// A div lowered below the count terminates on the next run edge.
module clk_prescaler
  import clk_tick_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             term
);

  logic [DIV_W-1:0] presc;
  logic             hit;

  assign hit  = presc >= div;
  assign term = run & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (run) begin
      presc <= hit ? '0 : presc + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clk_tick_counter.sv
// Programmable tick, divided clock and step accumulator.
// Optional sim monitor: define CLK_TICK_COUNTER_DISPLAY_EN.
module clk_tick_counter
  import clk_tick_pkg::*;
#(
  parameter int          DIV_W = DEF_DIV_W,
  parameter int          CNT_W = DEF_CNT_W,
  parameter int unsigned STEP  = DEF_STEP
) (
  input  logic               clk,
  input  logic               rst,
  clk_tick_counter_if.slave  bus
);

  state_t           state;
  logic             run;
  logic             term;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;
  logic             clkd_q;
  logic             wrap_q;

  assign run = (state == RUN);
  assign sum = {1'b0, cnt_q} + (CNT_W+1)'(STEP);

  clk_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (bus.load),
    .div  (bus.div),
    .term (term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      clkd_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (bus.en)  state <= RUN;
        RUN:     if (!bus.en) state <= PAUSE;
        PAUSE:   if (bus.en)  state <= RUN;
        default: state <= IDLE;
      endcase
      // load wins over a coincident terminal count
      if (bus.load) begin
        cnt_q  <= bus.load_val;
        tick_q <= 1'b0;
        wrap_q <= 1'b0;
      end else if (term) begin
        cnt_q  <= sum[CNT_W-1:0];
        wrap_q <= sum[CNT_W];
        tick_q <= 1'b1;
        clkd_q <= ~clkd_q;
      end else begin
        tick_q <= 1'b0;
        wrap_q <= 1'b0;
      end
    end
  end

  assign bus.count   = cnt_q;
  assign bus.tick    = tick_q;
  assign bus.clk_div = clkd_q;
  assign bus.wrap    = wrap_q;

`ifdef CLK_TICK_COUNTER_DISPLAY_EN
  always @(posedge clk) begin
    if (tick_q) $display("%0t tick count=%0d", $time, cnt_q);
    if (wrap_q) $display("%0t wrap", $time);
  end
`else
`endif

endmodule

// File: tb/tb_clk_tick_counter.sv
// Directed bench for clk_tick_counter.
// Two instances: default widths and an 8-bit accumulator.
module tb_clk_tick_counter;
  import clk_tick_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  clk_tick_counter_if #(.DIV_W(16), .CNT_W(32)) bus ();
  clk_tick_counter_if #(.DIV_W(16), .CNT_W(8))  bus8 ();

  clk_tick_counter #(.DIV_W(16), .CNT_W(32), .STEP(10)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clk_tick_counter #(.DIV_W(16), .CNT_W(8), .STEP(10)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.en = 0; bus.div = '0; bus.load = 0; bus.load_val = '0;
    bus8.en = 0; bus8.div = '0; bus8.load = 0; bus8.load_val = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (u_dut.state !== IDLE || bus.tick !== 0 || bus.count !== 0
        || bus.clk_div !== 0 || bus.wrap !== 0) begin
      errors++;
      $display("FAIL reset_init: state=%0d tick=%b cnt=%0d cd=%b wrap=%b want IDLE/0",
               u_dut.state, bus.tick, bus.count, bus.clk_div, bus.wrap);
    end
    bus.div = 16'd4;
    bus.en  = 1;
    repeat (24) step();
    checks++;
    if (bus.count !== 32'd40 || u_dut.u_presc.presc !== 16'd3) begin
      errors++;
      $display("FAIL reset_precond: cnt=%0d presc=%0d want 40/3",
               bus.count, u_dut.u_presc.presc);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.tick !== 0 || bus.count !== 0 || bus.clk_div !== 0
        || bus.wrap !== 0 || u_dut.u_presc.presc !== 0) begin
      errors++;
      $display("FAIL reset_async: tick=%b cnt=%0d cd=%b wrap=%b presc=%0d want 0",
               bus.tick, bus.count, bus.clk_div, bus.wrap,
               u_dut.u_presc.presc);
    end
    bus.en = 0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (u_dut.state !== IDLE || bus.tick !== 0 || bus.count !== 0) begin
      errors++;
      $display("FAIL reset_release: state=%0d tick=%b cnt=%0d want IDLE/0/0",
               u_dut.state, bus.tick, bus.count);
    end
  endtask

  task automatic test_basic_div();
    int n;
    logic et;
    do_reset();
    bus.div = 16'd4;
    bus.en  = 1;
    for (int k = 1; k <= 51; k++) begin
      step();
      n  = (k >= 6) ? (k - 6) / 5 + 1 : 0;
      et = (k >= 6) && ((k - 6) % 5 == 0);
      checks++;
      if (bus.tick !== et || bus.count !== 32'(10 * n)
          || bus.clk_div !== n[0] || bus.wrap !== 0) begin
        errors++;
        $display("FAIL basic_div k=%0d: tick=%b cnt=%0d cd=%b wrap=%b want %b/%0d/%b/0",
                 k, bus.tick, bus.count, bus.clk_div, bus.wrap,
                 et, 10 * n, n[0]);
      end
    end
    checks++;
    if (bus.count !== 32'd100) begin
      errors++;
      $display("FAIL basic_div_final: cnt=%0d want 100", bus.count);
    end
  endtask

  task automatic test_min_div();
    int n;
    do_reset();
    bus.div = 16'd0;
    bus.en  = 1;
    for (int k = 1; k <= 11; k++) begin
      step();
      n = k - 1;
      checks++;
      if (bus.tick !== (k > 1) || bus.count !== 32'(10 * n)
          || bus.clk_div !== n[0]) begin
        errors++;
        $display("FAIL min_div k=%0d: tick=%b cnt=%0d cd=%b want %b/%0d/%b",
                 k, bus.tick, bus.count, bus.clk_div, k > 1, 10 * n, n[0]);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    bus.div = 16'd9;
    bus.en  = 1;
    for (int k = 1; k <= 18; k++) begin
      step();
      checks++;
      if (bus.tick !== (k == 18) || bus.count !== ((k == 18) ? 32'd10 : 32'd0)) begin
        errors++;
        $display("FAIL pause k=%0d: tick=%b cnt=%0d want %b/%0d",
                 k, bus.tick, bus.count, k == 18, (k == 18) ? 10 : 0);
      end
      if (k >= 8 && k <= 15) begin
        checks++;
        if (u_dut.u_presc.presc !== 16'd7) begin
          errors++;
          $display("FAIL pause_hold k=%0d: presc=%0d want 7",
                   k, u_dut.u_presc.presc);
        end
      end
      if (k == 7)  bus.en = 0;
      if (k == 14) bus.en = 1;
    end
  endtask

  task automatic test_shrink_div();
    int n;
    logic et;
    do_reset();
    bus.div = 16'd20;
    bus.en  = 1;
    n = 0;
    for (int k = 1; k <= 29; k++) begin
      step();
      et = (k == 17) || (k == 23) || (k == 29);
      if (et) n++;
      checks++;
      if (bus.tick !== et || bus.count !== 32'(10 * n)) begin
        errors++;
        $display("FAIL shrink_div k=%0d: tick=%b cnt=%0d want %b/%0d",
                 k, bus.tick, bus.count, et, 10 * n);
      end
      if (k == 16) bus.div = 16'd5;
    end
  endtask

  task automatic test_load_collision();
    do_reset();
    bus8.div = 16'd2;
    bus8.en  = 1;
    repeat (3) step();
    bus8.load     = 1;
    bus8.load_val = 8'd250;
    step();
    checks++;
    if (bus8.count !== 8'd250 || bus8.tick !== 0 || bus8.wrap !== 0
        || bus8.clk_div !== 0) begin
      errors++;
      $display("FAIL load_collide: cnt=%0d tick=%b wrap=%b cd=%b want 250/0/0/0",
               bus8.count, bus8.tick, bus8.wrap, bus8.clk_div);
    end
    bus8.load = 0;
    repeat (3) step();
    checks++;
    if (bus8.count !== 8'd4 || bus8.tick !== 1 || bus8.wrap !== 1
        || bus8.clk_div !== 1) begin
      errors++;
      $display("FAIL load_wrap: cnt=%0d tick=%b wrap=%b cd=%b want 4/1/1/1",
               bus8.count, bus8.tick, bus8.wrap, bus8.clk_div);
    end
    step();
    checks++;
    if (bus8.count !== 8'd4 || bus8.tick !== 0 || bus8.wrap !== 0) begin
      errors++;
      $display("FAIL wrap_pulse: cnt=%0d tick=%b wrap=%b want 4/0/0",
               bus8.count, bus8.tick, bus8.wrap);
    end
  endtask

  task automatic test_load_paused();
    bus8.en       = 0;
    bus8.load     = 1;
    bus8.load_val = 8'd7;
    step();
    bus8.load = 0;
    step();
    checks++;
    if (u_dut8.state !== PAUSE || bus8.count !== 8'd7 || bus8.tick !== 0) begin
      errors++;
      $display("FAIL load_paused: state=%0d cnt=%0d tick=%b want PAUSE/7/0",
               u_dut8.state, bus8.count, bus8.tick);
    end
  endtask

  initial begin
    bus.en = 0; bus.div = '0; bus.load = 0; bus.load_val = '0;
    bus8.en = 0; bus8.div = '0; bus8.load = 0; bus8.load_val = '0;
    test_reset();
    test_basic_div();
    test_min_div();
    test_pause();
    test_shrink_div();
    test_load_collision();
    test_load_paused();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_tick_counter.md
Name: clk_tick_counter

Overview:
- Consumes the free-running `clk` from the clock source.
- Produces three outputs:
  - a programmable-rate single-cycle tick;
  - a divided clock that toggles on every tick;
  - a step accumulator that adds STEP on every tick.
- Used by downstream timing and monitor stages in place of ad-hoc `wait(clk)` counters.
- Fully synchronous to `clk`; synthesizable apart from the optional display feature.

Parameters:
- DIV_W, 16: width of the divide-ratio input and of the internal prescaler.
- CNT_W, 32: width of the accumulator.
- STEP, 10: constant added to the accumulator per tick. Must satisfy 0 < STEP < 2^CNT_W.

Ports:
- clk       input   1       system clock; all logic on rising edge
- rst       input   1       asynchronous, active-high reset
- en        input   1       run enable; low pauses the block
- div       input   DIV_W   terminal count; tick period = div+1 enabled cycles
- load      input   1       synchronous load of accumulator
- load_val  input   CNT_W   value loaded when load=1
- tick      output  1       one-cycle pulse at each terminal count
- clk_div   output  1       divided clock; toggles on each tick
- count     output  CNT_W   accumulator value
- wrap      output  1       one-cycle pulse when an accumulator add overflows

Behaviour:
- Reset (rst=1, asynchronous, any time, including mid-period):
  - prescaler=0, count=0, tick=0, clk_div=0, wrap=0;
  - FSM goes to IDLE.
- FSM states:
  - IDLE:
    - prescaler held, tick=0;
    - en=1 -> RUN on the next edge. The prescaler starts counting in the first RUN cycle.
  - RUN:
    - each edge: if prescaler >= div, assert terminal: prescaler<=0, tick<=1. Otherwise prescaler<=prescaler+1, tick<=0.
    - en=0 -> PAUSE.
  - PAUSE:
    - prescaler and count held, tick=0;
    - en=1 -> RUN and the count resumes from the held prescaler value;
    - load while paused is still honoured.
- Outputs are registered. tick, wrap and the count update all appear in the same cycle, one edge after the terminal condition is sampled.
- On tick:
  - count <= (count+STEP) mod 2^CNT_W;
  - wrap <= carry-out of that addition;
  - clk_div <= ~clk_div.
- Tick rate:
  - div=0: tick every RUN cycle; clk_div = clk/2.
  - div=N: tick every N+1 RUN cycles; clk_div period = 2(N+1) cycles.
- div changed mid-period: the `>=` compare makes a new div below the current prescaler terminate on the next RUN edge. There is no lock-up and no 2^DIV_W-cycle overrun.
- load=1 takes priority over tick in the same cycle:
  - count<=load_val, prescaler<=0;
  - tick, wrap and clk_div do not change that cycle (tick=0, wrap=0).
- en low and load on the same edge: the load is applied and the FSM goes to PAUSE or stays in IDLE.
- All outputs are glitch-free registered signals. clk_div must not be used as a clock inside this block.

Optional Feature:
- Macro: CLK_TICK_COUNTER_DISPLAY_EN.
- Defined: simulation-only monitor. On each tick it prints `$time` and `count` via `$display`. On each wrap it prints a "wrap" line with `$time`. No effect on RTL outputs.
- Undefined: no display code is compiled. Netlist and behaviour are identical.

Decomposition:
- Package clk_tick_pkg holds:
  - state enum (IDLE, RUN, PAUSE);
  - default constants DEF_DIV_W=16, DEF_CNT_W=32, DEF_STEP=10.
- Sub-module clk_prescaler:
  - ports: clk, rst, run, clr, div -> terminal pulse;
  - contents: the prescaler register plus the `>=` compare.
- The top level holds the FSM, accumulator, clk_div toggle and the optional display.

Test Plan:
- Reset behaviour:
  - stimulus: assert rst mid-count (prescaler=3, count=40);
  - required: all outputs 0 immediately, without waiting for a clk edge; FSM in IDLE after release.
- Basic division:
  - stimulus: div=4, en=1 for 50 cycles;
  - required: tick every 5 cycles; count = 0,10,20,... reaching 100 after 10 ticks; clk_div period 10 cycles.
- Minimum divide:
  - stimulus: div=0;
  - required: tick high every RUN cycle; clk_div toggles every cycle; count +10 per cycle.
- Pause and resume:
  - stimulus: div=9; drop en at prescaler=6 for 7 cycles; raise en;
  - required: no tick while paused; next tick exactly 3 RUN cycles after resume.
- Load versus tick collision:
  - stimulus: CNT_W=8, load_val=250 asserted on a terminal cycle;
  - required: count=250, tick=0, wrap=0 that cycle.
  - follow-on: the next tick gives count=4 with wrap=1.
- Shrinking div:
  - stimulus: div=20 with prescaler=15, then div changed to 5;
  - required: tick on the next edge; afterwards period is 6 cycles.
